// File: rtl/led_pio_pkg.sv
// rtl/led_pio_pkg.sv - shared register map for the LED PWM PIO
package led_pio_pkg;

    typedef logic [2:0] reg_addr_t;

    localparam reg_addr_t ADDR_DATA       = 3'd0;
    localparam reg_addr_t ADDR_SET        = 3'd1;
    localparam reg_addr_t ADDR_CLR        = 3'd2;
    localparam reg_addr_t ADDR_DUTY       = 3'd3;
    localparam reg_addr_t ADDR_BLINK_MASK = 3'd4;
    localparam reg_addr_t ADDR_BLINK_PER  = 3'd5;

endpackage

// File: rtl/led_pio_blink_gen.sv
// rtl/led_pio_blink_gen.sv - blink prescaler: half-period of per_i+1 cycles, restartable via load_i
module led_pio_blink_gen #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] per_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         phase_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (load_i) begin
            cnt_d   = load_val_i;
            phase_d = 1'b1;
        end else if (per_i == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == '0) begin
            cnt_d   = per_i;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/tag_nios_system_led_pwm_pio.sv
// rtl/tag_nios_system_led_pwm_pio.sv - Avalon-MM LED PIO with set/clear, PWM and optional blink
// Blink logic is built only when LED_PWM_PIO_BLINK_EN is defined.
module tag_nios_system_led_pwm_pio
    import led_pio_pkg::*;
#(
    parameter int               WIDTH      = 10,
    parameter int               DUTY_W     = 8,
    parameter int               BLINK_W    = 24,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    reg_addr_t          addr;
    logic               wr;
    logic [WIDTH-1:0]   wd;
    logic               unused_wd;

    logic [WIDTH-1:0]   data_q, data_d;
    logic [DUTY_W-1:0]  duty_q, duty_d;
    logic [DUTY_W-1:0]  pwm_cnt_q;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               pwm_on;
    logic [WIDTH-1:0]   blink_mask;
    logic               blink_phase;

    assign addr      = reg_addr_t'(address);
    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = &{1'b0, writedata};

    always_comb begin
        data_d = data_q;
        duty_d = duty_q;
        if (wr) begin
            case (addr)
                ADDR_DATA: data_d = wd;
                ADDR_SET:  data_d = data_q | wd;
                ADDR_CLR:  data_d = data_q & ~wd;
                ADDR_DUTY: duty_d = writedata[DUTY_W-1:0];
                default:   ;
            endcase
        end
    end

`ifdef LED_PWM_PIO_BLINK_EN
    logic [WIDTH-1:0]   blink_mask_q;
    logic [BLINK_W-1:0] blink_per_q;
    logic               per_load;

    assign per_load   = wr && (addr == ADDR_BLINK_PER);
    assign blink_mask = blink_mask_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_mask_q <= '0;
            blink_per_q  <= '0;
        end else if (wr) begin
            if (addr == ADDR_BLINK_MASK) blink_mask_q <= wd;
            if (per_load)                blink_per_q  <= writedata[BLINK_W-1:0];
        end
    end

    // Restart takes the freshly written period so the first half-period is full length.
    led_pio_blink_gen #(.W(BLINK_W)) u_blink (
        .clk        (clk),
        .reset_n    (reset_n),
        .per_i      (blink_per_q),
        .load_i     (per_load),
        .load_val_i (writedata[BLINK_W-1:0]),
        .phase_o    (blink_phase)
    );
`else
    assign blink_mask  = '0;
    assign blink_phase = 1'b1;
`endif

    // All-ones duty is forced on so the output never drops for the wrap cycle.
    assign pwm_on = (duty_q == {DUTY_W{1'b1}}) | (pwm_cnt_q < duty_q);
    assign out_d  = data_q & {WIDTH{pwm_on}} & (~blink_mask | {WIDTH{blink_phase}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q    <= RESET_DATA;
            duty_q    <= '1;
            pwm_cnt_q <= '0;
            out_q     <= '0;
        end else begin
            data_q    <= data_d;
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            out_q     <= out_d;
        end
    end

    assign out_port = out_q;

    always_comb begin
        readdata = '0;
        case (addr)
            ADDR_DATA, ADDR_SET, ADDR_CLR: readdata = 32'(data_q);
            ADDR_DUTY:                     readdata = 32'(duty_q);
`ifdef LED_PWM_PIO_BLINK_EN
            ADDR_BLINK_MASK:               readdata = 32'(blink_mask_q);
            ADDR_BLINK_PER:                readdata = 32'(blink_per_q);
`endif
            default:                       readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_tag_nios_system_led_pwm_pio.sv
// tb/tb_tag_nios_system_led_pwm_pio.sv - randomized self-checking bench against a behavioural model
module tb_tag_nios_system_led_pwm_pio;

`ifdef LED_PWM_PIO_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [9:0]  out_port;

    int n_chk = 0;
    int n_pass = 0;

    tag_nios_system_led_pwm_pio #(
        .WIDTH(10), .DUTY_W(8), .BLINK_W(24), .RESET_DATA(10'h000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    // Behavioural model: PWM phase from cycle count, blink phase from time since last period write.
    logic [9:0] m_data, m_mask, m_out;
    longint     m_duty, m_per, m_cyc, m_bt;

    always @(posedge clk or negedge reset_n) begin : model
        logic on, ph;
        if (!reset_n) begin
            m_data <= 10'h000; m_duty <= 255; m_mask <= '0; m_per <= 0;
            m_cyc  <= 0;       m_bt   <= 0;   m_out  <= '0;
        end else begin
            on = (m_duty == 255) || ((m_cyc % 256) < m_duty);
            ph = (m_per == 0) || (((m_bt / (m_per + 1)) % 2) == 0);
            m_out <= m_data & (on ? 10'h3FF : 10'h000) & (~m_mask | (ph ? 10'h3FF : 10'h000));
            m_cyc <= m_cyc + 1;
            m_bt  <= m_bt + 1;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data <= writedata[9:0];
                    3'd1: m_data <= m_data | writedata[9:0];
                    3'd2: m_data <= m_data & ~writedata[9:0];
                    3'd3: m_duty <= longint'(writedata[7:0]);
                    3'd4: if (BLINK_ON) m_mask <= writedata[9:0];
                    3'd5: if (BLINK_ON) begin m_per <= longint'(writedata[23:0]); m_bt <= 0; end
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [31:0] m_rd(input int a);
        case (a)
            0, 1, 2: return {22'd0, m_data};
            3:       return 32'(m_duty);
            4:       return {22'd0, m_mask};
            5:       return 32'(m_per);
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic cyc_chk();
        @(negedge clk);
        check("out_port", {22'd0, out_port}, {22'd0, m_out});
    endtask

    task automatic bus_wr(input int a, input logic [31:0] d);
        address = 3'(a); writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cyc_chk();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input int a);
        address = 3'(a);
        #1;
        check(tag, readdata, m_rd(a));
    endtask

    initial begin
        int hi;
        int tr;
        logic prev;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("rst_out", {22'd0, out_port}, 32'h0);
        address = 3'd0; #1; check("rst_data", readdata, 32'h000);
        address = 3'd3; #1; check("rst_duty", readdata, 32'h0FF);

        bus_wr(0, 32'h3FF);
        repeat (3) cyc_chk();
        check("data_on", {22'd0, out_port}, 32'h3FF);
        reset_n = 1'b0;
        #1;
        check("async_rst", {22'd0, out_port}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd_chk("rst2_data", 0);
        rd_chk("rst2_duty", 3);

        bus_wr(0, 32'h00F);
        bus_wr(1, 32'h300);
        bus_wr(2, 32'h005);
        address = 3'd0; #1; check("setclr_rd", readdata, 32'h30A);
        cyc_chk();
        cyc_chk();
        check("setclr_out", {22'd0, out_port}, 32'h30A);

        bus_wr(0, 32'h001);
        bus_wr(3, 32'h040);
        cyc_chk();
        hi = 0;
        for (int i = 0; i < 256; i++) begin cyc_chk(); hi += int'(out_port[0]); end
        check("pwm_64", 32'(hi), 32'd64);
        bus_wr(3, 32'h000);
        cyc_chk();
        hi = 0;
        for (int i = 0; i < 256; i++) begin cyc_chk(); hi += int'(out_port[0]); end
        check("pwm_0", 32'(hi), 32'd0);
        bus_wr(3, 32'h0FF);
        cyc_chk();
        hi = 0;
        for (int i = 0; i < 300; i++) begin cyc_chk(); hi += int'(out_port[0]); end
        check("pwm_full", 32'(hi), 32'd300);

`ifdef LED_PWM_PIO_BLINK_EN
        bus_wr(0, 32'h003);
        bus_wr(4, 32'h002);
        bus_wr(5, 32'd3);
        tr = 0;
        prev = out_port[1];
        for (int k = 1; k <= 24; k++) begin
            cyc_chk();
            check("blink_b0", {31'd0, out_port[0]}, 32'd1);
            if (k > 1 && out_port[1] != prev) tr++;
            prev = out_port[1];
        end
        check("blink_tog4", 32'(tr), 32'd5);
        bus_wr(5, 32'd7);
        tr = 0;
        for (int k = 1; k <= 32; k++) begin
            cyc_chk();
            if (k == 1) check("blink_restart", {31'd0, out_port[1]}, 32'd1);
            if (k > 1 && out_port[1] != prev) tr++;
            prev = out_port[1];
        end
        check("blink_tog8", 32'(tr), 32'd3);
        rd_chk("rd_per", 5);
        rd_chk("rd_mask", 4);
`else
        bus_wr(0, 32'h3FF);
        bus_wr(4, 32'h3FF);
        address = 3'd4; #1; check("nomacro_mask", readdata, 32'h0);
        bus_wr(5, 32'd2);
        address = 3'd5; #1; check("nomacro_per", readdata, 32'h0);
        for (int k = 0; k < 16; k++) cyc_chk();
        check("nomacro_out", {22'd0, out_port}, 32'h3FF);
`endif

        bus_wr(0, 32'h155);
        bus_wr(6, 32'hFFFF_FFFF);
        address = 3'd6; #1; check("unmapped_rd", readdata, 32'h0);
        address = 3'd0; #1; check("unmapped_keep", readdata, 32'h155);
        bus_wr(0, 32'hFFFF_FFFF);
        address = 3'd0; #1; check("width_rd", readdata, 32'h3FF);

        for (int i = 0; i < 600; i++) begin
            int a;
            logic [31:0] d;
            a = int'($urandom_range(0, 7));
            rd_chk("rand_rd", a);
            d = $urandom;
            if (a == 5) d = 32'($urandom_range(0, 5));
            if (a == 3 && $urandom_range(0, 2) == 0) d = 32'hFF;
            if ($urandom_range(0, 2) == 0) bus_wr(a, d);
            else cyc_chk();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tag_nios_system_led_pwm_pio.md
Name: tag_nios_system_led_pwm_pio

Overview:
Parametrised Avalon-MM output PIO that drives board LEDs, generalising the fixed 10-bit LED port.
- Adds atomic set/clear writes, a global PWM brightness control and per-channel hardware blink.
- Sits on the Nios/HPS lightweight bus as an s1 slave with zero-wait-state reads.
- Its out_port feeds the LED pins directly.

Parameters:
WIDTH, 10, number of output channels (1..32)
DUTY_W, 8, PWM counter/duty width (2..16)
BLINK_W, 24, blink prescaler width (1..32)
RESET_DATA, 0, reset value of the DATA register (WIDTH bits)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational from address (0 wait states)
out_port  out  WIDTH  registered LED drive

Behaviour:
- Reset: reset_n is asynchronous and active-low; clk is the clock. Reset values:
  - DATA=RESET_DATA, DUTY=all-ones, BLINK_MASK=0, BLINK_PER=0.
  - pwm_cnt=0, blink_cnt=0, blink_phase=1, out_port=0.
- Write qualifier: wr = chipselect & ~write_n. All register updates take effect on the clk edge of wr.
- Register map (word addresses):
  - 0 DATA (R/W): WIDTH bits.
  - 1 SET (W): DATA |= writedata[WIDTH-1:0]. Reads return DATA.
  - 2 CLR (W): DATA &= ~writedata[WIDTH-1:0]. Reads return DATA.
  - 3 DUTY (R/W): DUTY_W bits.
  - 4 BLINK_MASK (R/W): WIDTH bits.
  - 5 BLINK_PER (R/W): BLINK_W bits.
  - 6, 7: read 0, writes ignored.
- Readdata: unused upper bits are 0. chipselect is not required for reads (combinational mux on address).
- PWM:
  - pwm_cnt is a free-running DUTY_W counter that wraps all-ones -> 0.
  - pwm_on = (DUTY == all-ones) | (pwm_cnt < DUTY).
  - DUTY=0 gives always off; DUTY=all-ones gives always on (no glitch at wrap).
- Blink:
  - If BLINK_PER==0: blink_phase is held at 1 and blink_cnt at 0.
  - Otherwise blink_cnt counts down each cycle. At 0 it reloads BLINK_PER and blink_phase toggles, so the half-period is BLINK_PER+1 cycles.
  - A write to BLINK_PER forces blink_cnt=new value and blink_phase=1 on the same edge, so it restarts cleanly.
- Output: out_port[i] <= DATA[i] & pwm_on & (~BLINK_MASK[i] | blink_phase). Registered, so there is one cycle of latency from register or counter state to the pin.
  - A write to DATA is visible on out_port 2 edges after the write edge.
- With DUTY all-ones and BLINK_MASK 0, behaviour equals a plain PIO apart from the extra output register stage.
- Simultaneous events: only one address per cycle, so SET/CLR/DATA writes cannot collide. Counters keep running during bus writes. A DUTY write takes effect on the next compare and does not reset pwm_cnt.
- Reset asserted mid-operation: everything returns to the reset values asynchronously; out_port=0 immediately.

Optional Feature:
Macro LED_PWM_PIO_BLINK_EN.
- Defined: BLINK_MASK, BLINK_PER, blink_cnt and blink_phase are implemented as specified above.
- Undefined: no blink logic is built. Addresses 4 and 5 read 0 and ignore writes, and the output term reduces to DATA[i] & pwm_on.

Decomposition:
- Shared package led_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_SET=1, ADDR_CLR=2, ADDR_DUTY=3, ADDR_BLINK_MASK=4, ADDR_BLINK_PER=5;
  - a typedef for the 3-bit register address.
- One natural sub-module, led_pio_blink_gen (prescaler, reload and phase toggle, with a load/load_val input for restart). It is instantiated only under LED_PWM_PIO_BLINK_EN.

Test Plan:
- Reset values: assert reset_n=0 mid-run with DATA=0x3FF -> out_port=0 immediately. After release, readdata at addr0=0 and addr3=0xFF.
- Set/clear: write DATA=0x00F, SET 0x300, CLR 0x005 -> addr0 reads 0x30A; out_port=0x30A two edges after the CLR write (DUTY=0xFF).
- PWM duty: DUTY=0x40, DATA=0x001 -> out_port[0] is high exactly 64 of every 256 cycles. DUTY=0 -> never high; DUTY=0xFF -> continuously high across the wrap.
- Blink: BLINK_PER=3, BLINK_MASK=0x002, DATA=0x003, DUTY=0xFF -> bit1 toggles every 4 cycles while bit0 stays high. Writing BLINK_PER=7 mid-period restarts with phase 1, then toggles every 8 cycles.
- Unmapped/width: write 0xFFFFFFFF to addr6 -> no state change, and addr6 reads 0. Write 0xFFFFFFFF to addr0 -> reads 0x000003FF.
- Macro off: build without LED_PWM_PIO_BLINK_EN, write addr4=0x3FF -> reads 0, and out_port is unaffected by blink.
